full_adder_unit: RTL and testbench

- Bit-sliced full-adder array: WIDTH one-bit full adders, each computing the sum and carry of operands a, b and carry-in c.
- Primitive used by the 4-bit ripple adders and BCD adders, so the combinational outputs must be exact gate-level full-adder equivalents.
- Optional internal ripple chaining (CHAIN=1) turns the array into a WIDTH-bit ripple-carry adder.
- Registered copies of the results with a valid flag are provided for pipelined use.

---
 rtl/full_adder_unit.sv | 67 ++++++
 tb/tb_full_adder_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/full_adder_unit.sv
// Array of WIDTH one-bit full adders with optional ripple chaining and a
// registered, valid-qualified copy of the results.
module full_adder_unit #(
  parameter int WIDTH = 1,
  parameter bit CHAIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_cout;
  logic [WIDTH-1:0] r_sum_q;
  logic [WIDTH-1:0] r_cout_q;
  logic             r_valid;

  // The running carry is a local variable so the chain is evaluated in slice
  // order inside one block instead of looping through a shared vector.
  always_comb begin
    logic w_ci;
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves a bit unassigned, which would otherwise infer a latch.
    w_sum  = '0;
    w_cout = '0;
    w_ci   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: blocking assignments here are intentional; w_ci must carry the
      // value just computed for slice i-1 within the same evaluation.
      if (!CHAIN || i == 0) w_ci = cin[i];
      w_sum[i]  = a[i] ^ b[i] ^ w_ci;
      w_cout[i] = (a[i] & b[i]) | (w_ci & (a[i] ^ b[i]));
      w_ci      = w_cout[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q  <= '0;
      r_cout_q <= '0;
      r_valid  <= 1'b0;
    end else if (in_valid) begin
      r_sum_q  <= w_sum;
      r_cout_q <= w_cout;
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign sum       = w_sum;
  assign cout      = w_cout;
  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench: three configurations of full_adder_unit checked against
// an arithmetic model every negedge, plus hand-computed directed vectors.
module tb_full_adder_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, c4 = '0;

  logic       s1, co1, sq1, cq1, ov1;
  logic [3:0] s4c, co4c, sq4c, cq4c;
  logic       ov4c;
  logic [3:0] s4i, co4i, sq4i, cq4i;
  logic       ov4i;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tt_sum  = 8'b1001_0110;
  logic [7:0] tt_cout = 8'b1110_1000;

  // model register state, {cout,sum}
  logic [7:0] m1, m4c, m4i;
  logic       m_v;

  full_adder_unit #(.WIDTH(1), .CHAIN(1'b0)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(in_valid),
    .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1));

  full_adder_unit #(.WIDTH(4), .CHAIN(1'b1)) u4c (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .in_valid(in_valid),
    .sum(s4c), .cout(co4c), .sum_q(sq4c), .cout_q(cq4c), .out_valid(ov4c));

  full_adder_unit #(.WIDTH(4), .CHAIN(1'b0)) u4i (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .in_valid(in_valid),
    .sum(s4i), .cout(co4i), .sum_q(sq4i), .cout_q(cq4i), .out_valid(ov4i));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {cout[3:0], sum[3:0]} from plain integer addition.
  function automatic logic [7:0] model(input int w, input bit chain,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
    logic [3:0] s = '0, co = '0;
    int t;
    for (int i = 0; i < w; i++) begin
      if (chain) begin
        // carry out of slice i is the carry past bit i of the low (i+1)-bit sum
        t = (int'(a) % (1 << (i + 1))) + (int'(b) % (1 << (i + 1))) + int'(c[0]);
        co[i] = ((t >> (i + 1)) & 1) != 0;
        s[i]  = ((t >> i) & 1) != 0;
      end else begin
        t = int'(a[i]) + int'(b[i]) + int'(c[i]);
        s[i]  = (t % 2) != 0;
        co[i] = (t / 2) != 0;
      end
    end
    return {co, s};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = '0; m4c = '0; m4i = '0; m_v = 1'b0;
    end else if (in_valid) begin
      m1  = model(1, 1'b0, {3'b0, a1}, {3'b0, b1}, {3'b0, c1});
      m4c = model(4, 1'b1, a4, b4, c4);
      m4i = model(4, 1'b0, a4, b4, c4);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e1, e4c, e4i;
    e1  = model(1, 1'b0, {3'b0, a1}, {3'b0, b1}, {3'b0, c1});
    e4c = model(4, 1'b1, a4, b4, c4);
    e4i = model(4, 1'b0, a4, b4, c4);
    check("u1_sum",      32'(s1),   32'(e1[0]));
    check("u1_cout",     32'(co1),  32'(e1[4]));
    check("u4c_sum",     32'(s4c),  32'(e4c[3:0]));
    check("u4c_cout",    32'(co4c), 32'(e4c[7:4]));
    check("u4i_sum",     32'(s4i),  32'(e4i[3:0]));
    check("u4i_cout",    32'(co4i), 32'(e4i[7:4]));
    check("u1_sum_q",    32'(sq1),  32'(m1[0]));
    check("u1_cout_q",   32'(cq1),  32'(m1[4]));
    check("u4c_sum_q",   32'(sq4c), 32'(m4c[3:0]));
    check("u4c_cout_q",  32'(cq4c), 32'(m4c[7:4]));
    check("u4i_sum_q",   32'(sq4i), 32'(m4i[3:0]));
    check("u4i_cout_q",  32'(cq4i), 32'(m4i[7:4]));
    check("u1_valid",    32'(ov1),  32'(m_v));
    check("u4c_valid",   32'(ov4c), 32'(m_v));
    check("u4i_valid",   32'(ov4i), 32'(m_v));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] idx;
    // reset state
    #2;
    check("rst_u1_sum_q",  32'(sq1),  32'd0);
    check("rst_u4c_sum_q", 32'(sq4c), 32'd0);
    check("rst_u4c_cout_q",32'(cq4c), 32'd0);
    check("rst_u4c_valid", 32'(ov4c), 32'd0);
    // literal pins on the model itself
    check("model_9p9p1",   32'(model(4, 1'b1, 4'd9, 4'd9, 4'd1)), 32'h93);
    check("model_indep",   32'(model(4, 1'b0, 4'b1010, 4'b0110, 4'b1100)), 32'he0);
    step(); step();
    rst = 1'b0;

    // exhaustive single-slice truth table
    for (int k = 0; k < 8; k++) begin
      step();
      idx = 3'(k);
      {a1, b1, c1} = idx;
      #1;
      check("tt_sum",  32'(s1),  32'(tt_sum[idx]));
      check("tt_cout", 32'(co1), 32'(tt_cout[idx]));
    end

    // ripple chaining
    step(); a4 = 4'd9;  b4 = 4'd9; c4 = 4'd1; #1;
    check("chain_9_9_1_sum",  32'(s4c),     32'b0011);
    check("chain_9_9_1_cout", 32'(co4c[3]), 32'd1);
    step(); a4 = 4'd0;  b4 = 4'd9; c4 = 4'd0; #1;
    check("chain_0_9_sum",    32'(s4c),     32'd9);
    check("chain_0_9_cout",   32'(co4c[3]), 32'd0);
    step(); a4 = 4'd15; b4 = 4'd1; c4 = 4'd0; #1;
    check("chain_15_1_sum",   32'(s4c),     32'd0);
    check("chain_15_1_cout",  32'(co4c[3]), 32'd1);

    // independent slices
    step(); a4 = 4'b1010; b4 = 4'b0110; c4 = 4'b1100; #1;
    check("indep_sum",  32'(s4i),  32'b0000);
    check("indep_cout", 32'(co4i), 32'b1110);

    // registered path: one-cycle capture
    step(); a4 = 4'd3; b4 = 4'd5; c4 = 4'd0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("reg_sum_q",   32'(sq4c),     32'd8);
    check("reg_cout_q3", 32'(cq4c[3]),  32'd0);
    check("reg_valid",   32'(ov4c),     32'd1);
    step();
    check("reg_valid_drop", 32'(ov4c), 32'd0);
    check("reg_sum_hold",   32'(sq4c), 32'd8);

    // asynchronous reset pulse between edges
    step(); a4 = 4'd6; b4 = 4'd7; c4 = 4'd0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("pre_rst_sum_q", 32'(sq4c), 32'd13);
    check("pre_rst_valid", 32'(ov4c), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_sum_q",   32'(sq4c), 32'd0);
    check("arst_cout_q",  32'(cq4c), 32'd0);
    check("arst_valid",   32'(ov4c), 32'd0);
    check("arst_u4i_sum_q", 32'(sq4i), 32'd0);
    check("arst_comb_sum",  32'(s4c),  32'd13);
    check("arst_comb_cout", 32'(co4c), 32'b0110);
    #1 rst = 1'b0;
    step();
    check("post_rst_valid", 32'(ov4c), 32'd0);

    // back-to-back stream
    for (int k = 0; k < 20; k++) begin
      step();
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c4 = 4'($urandom_range(0, 15));
      {a1, b1, c1} = 3'($urandom_range(0, 7));
      in_valid = 1'b1;
    end
    step(); in_valid = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
